// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, op class and immediate format encodings
// Purpose: shared decode encodings for riscv_decode and riscv_imm_gen.
// Contents: OPC_* major opcodes, op_class_t (4-bit), imm_fmt_t (3-bit).
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'h0,
    CLS_AUIPC   = 4'h1,
    CLS_JAL     = 4'h2,
    CLS_JALR    = 4'h3,
    CLS_BRANCH  = 4'h4,
    CLS_LOAD    = 4'h5,
    CLS_STORE   = 4'h6,
    CLS_OPIMM   = 4'h7,
    CLS_OP      = 4'h8,
    CLS_FENCE   = 4'h9,
    CLS_SYSTEM  = 4'hA,
    CLS_MULDIV  = 4'hC,
    CLS_ILLEGAL = 4'hF
  } op_class_t;

  // IMM_NONE covers R-type, FENCE and illegal words: immediate is zero.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// rtl/riscv_imm_gen.sv - combinational RV32I immediate generator
// Purpose: assemble the sign-extended immediate for the selected format.
// Ports:
//   instr  in  [31:7]  instruction word (opcode bits not needed)
//   fmt    in  imm_fmt_t  immediate format
//   imm    out 32      sign-extended immediate (0 for IMM_NONE)
module riscv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decode.sv
// rtl/riscv_decode.sv - RV32I decode stage, one registered stage ahead of the register file
// Purpose: decode a fetched instruction into register indices, immediate, op class,
//   write enable and illegal flag behind a valid/ready handshake (latency 1).
// Option: define RISCV_DECODE_M_EXT_EN to decode OP funct7=0x01 as MULDIV.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_instr, in_pc payload
//   flush                    drop the held instruction (wins over accept)
//   out_valid/out_ready      downstream handshake
//   out_pc, out_rf_cs, out_rs1, out_rs2, out_rd, out_rd_wen, out_imm,
//   out_op_class, out_funct3, out_funct7b5, out_illegal   decoded fields
module riscv_decode
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RESET_PC_HOLD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_rf_cs,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_op_class,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  op_class_t  dec_cls;
  imm_fmt_t   dec_fmt;
  logic       dec_ill;
  logic       use_rs1;
  logic       use_rs2;
  logic       writes_rd;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;
  logic       dec_wen;
  logic [31:0] dec_imm;
  logic       accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_cls   = CLS_ILLEGAL;
    dec_fmt   = IMM_NONE;
    dec_ill   = 1'b0;
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_cls = CLS_LUI; dec_fmt = IMM_U; use_rs1 = 1'b0; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec_cls = CLS_AUIPC; dec_fmt = IMM_U; use_rs1 = 1'b0; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec_cls = CLS_JAL; dec_fmt = IMM_J; use_rs1 = 1'b0; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec_cls = CLS_JALR; dec_fmt = IMM_I; writes_rd = 1'b1;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_cls = CLS_BRANCH; dec_fmt = IMM_B; use_rs2 = 1'b1;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_cls = CLS_LOAD; dec_fmt = IMM_I; writes_rd = 1'b1;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_cls = CLS_STORE; dec_fmt = IMM_S; use_rs2 = 1'b1;
        dec_ill = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec_cls = CLS_OPIMM; dec_fmt = IMM_I; writes_rd = 1'b1;
        // Only the shift forms put a funct7 in the immediate field.
        if (funct3 == 3'b001)
          dec_ill = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec_ill = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec_cls = CLS_OP; use_rs2 = 1'b1; writes_rd = 1'b1;
        case (funct7)
          7'h00: dec_ill = 1'b0;
          7'h20: dec_ill = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef RISCV_DECODE_M_EXT_EN
          7'h01: dec_cls = CLS_MULDIV;
`else
          7'h01: dec_ill = 1'b1;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        dec_cls = CLS_FENCE;
      end
      OPC_SYSTEM: begin
        dec_cls = CLS_SYSTEM; dec_fmt = IMM_I;
      end
      default: dec_ill = 1'b1;
    endcase

    // Compressed/reserved encodings never match a listed opcode, but keep it explicit.
    if (in_instr[1:0] != 2'b11)
      dec_ill = 1'b1;

    if (dec_ill) begin
      dec_cls   = CLS_ILLEGAL;
      dec_fmt   = IMM_NONE;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
    end
  end

  assign dec_rs1 = use_rs1 ? in_instr[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? in_instr[24:20] : 5'd0;
  assign dec_rd  = dec_ill ? 5'd0 : in_instr[11:7];
  assign dec_wen = writes_rd && (in_instr[11:7] != 5'd0);

  riscv_imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_rf_cs = out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
      out_imm      <= '0;
      out_op_class <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      if (RESET_PC_HOLD == 0)
        out_pc <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1      <= dec_rs1;
      out_rs2      <= dec_rs2;
      out_rd       <= dec_rd;
      out_rd_wen   <= dec_wen;
      out_imm      <= dec_imm;
      out_op_class <= dec_cls;
      out_funct3   <= funct3;
      out_funct7b5 <= in_instr[30];
      out_illegal  <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_decode.sv
// tb/tb_riscv_decode.sv - self-checking bench for riscv_decode
module tb_riscv_decode;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic        out_rf_cs, out_rd_wen, out_funct7b5, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_op_class;
  logic [2:0]  out_funct3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_decode dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rf_cs(out_rf_cs), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_imm(out_imm), .out_op_class(out_op_class),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        wen, ill;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [31:0] s;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    s  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    f3 = ins[14:12];
    f7 = ins[31:25];
    legal = 1'b1;
    d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
    d.imm = 32'h0; d.cls = CLS_ILLEGAL; d.ill = 1'b0;
    case (ins[6:0])
      7'h37: begin d.cls = CLS_LUI;   d.imm = ins & 32'hFFFF_F000; end
      7'h17: begin d.cls = CLS_AUIPC; d.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        d.cls = CLS_JAL;
        d.imm = (s << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67: begin d.cls = CLS_JALR; d.imm = (s << 11) | 32'(ins[30:20]); legal = (f3 == 0); end
      7'h63: begin
        d.cls = CLS_BRANCH; legal = (f3 != 2) && (f3 != 3);
        d.imm = (s << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h03: begin d.cls = CLS_LOAD; d.imm = (s << 11) | 32'(ins[30:20]); legal = (f3 < 3) || (f3 == 4) || (f3 == 5); end
      7'h23: begin d.cls = CLS_STORE; d.imm = (s << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]); legal = (f3 <= 2); end
      7'h13: begin
        d.cls = CLS_OPIMM; d.imm = (s << 11) | 32'(ins[30:20]);
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
      end
      7'h33: begin
        d.cls = CLS_OP;
        if (f7 == 7'h20) legal = (f3 == 0) || (f3 == 5);
`ifdef RISCV_DECODE_M_EXT_EN
        else if (f7 == 7'h01) d.cls = CLS_MULDIV;
`endif
        else if (f7 != 7'h00) legal = 1'b0;
      end
      7'h0F: d.cls = CLS_FENCE;
      7'h73: begin d.cls = CLS_SYSTEM; d.imm = (s << 11) | 32'(ins[30:20]); end
      default: legal = 1'b0;
    endcase
    if (d.cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL}) d.rs1 = 5'd0;
    if (!(d.cls inside {CLS_OP, CLS_STORE, CLS_BRANCH, CLS_MULDIV})) d.rs2 = 5'd0;
    d.wen = (d.cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_OP, CLS_MULDIV})
            && (d.rd != 0);
    if (!legal) begin
      d.cls = CLS_ILLEGAL; d.ill = 1'b1; d.wen = 1'b0;
      d.rs1 = 5'd0; d.rs2 = 5'd0; d.rd = 5'd0; d.imm = 32'h0;
    end
    return d;
  endfunction

  // Immediate is not defined for illegal words, so it is only checked when legal.
  task automatic chk_dec(input string nm, input logic [31:0] ins, input dec_t e, input logic [31:0] pc);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".cs"},    32'(out_rf_cs), 32'd1);
    chk({nm, ".pc"},    out_pc, pc);
    chk({nm, ".cls"},   32'(out_op_class), 32'(e.cls));
    chk({nm, ".rs1"},   32'(out_rs1), 32'(e.rs1));
    chk({nm, ".rs2"},   32'(out_rs2), 32'(e.rs2));
    chk({nm, ".rd"},    32'(out_rd), 32'(e.rd));
    chk({nm, ".wen"},   32'(out_rd_wen), 32'(e.wen));
    chk({nm, ".ill"},   32'(out_illegal), 32'(e.ill));
    chk({nm, ".f3"},    32'(out_funct3), 32'(ins[14:12]));
    chk({nm, ".f7b5"},  32'(out_funct7b5), 32'(ins[30]));
    if (!e.ill) chk({nm, ".imm"}, out_imm, e.imm);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".cs"},    32'(out_rf_cs), 32'd0);
    chk({nm, ".pc"},    out_pc, 32'd0);
    chk({nm, ".cls"},   32'(out_op_class), 32'd0);
    chk({nm, ".regs"},  {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
    chk({nm, ".wen"},   32'(out_rd_wen), 32'd0);
    chk({nm, ".imm"},   out_imm, 32'd0);
    chk({nm, ".ill"},   32'(out_illegal), 32'd0);
    chk({nm, ".rdy"},   32'(in_ready), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(7) != 0) w[6:0] = opcs[$urandom_range(10)];
    if ($urandom_range(3) != 0) w[31:25] = f7s[$urandom_range(3)];
    return w;
  endfunction

  vec_t tbl [10];
  dec_t e;
  logic ev;
  dec_t ed;
  logic [31:0] epc, ein;
  logic exp_rdy;

  initial begin
    tbl[0] = '{32'h0050_0093, '{CLS_OPIMM,  5'd0, 5'd0, 5'd1,  32'h0000_0005, 1'b1, 1'b0}};
    tbl[1] = '{32'hFE21_AE23, '{CLS_STORE,  5'd3, 5'd2, 5'd28, 32'hFFFF_FFFC, 1'b0, 1'b0}};
    tbl[2] = '{32'h0000_0013, '{CLS_OPIMM,  5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b0, 1'b0}};
    tbl[3] = '{32'h0000_0000, '{CLS_ILLEGAL,5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b0, 1'b1}};
    tbl[4] = '{32'h1234_52B7, '{CLS_LUI,    5'd0, 5'd0, 5'd5,  32'h1234_5000, 1'b1, 1'b0}};
    tbl[5] = '{32'hFE20_8CE3, '{CLS_BRANCH, 5'd1, 5'd2, 5'd25, 32'hFFFF_FFF8, 1'b0, 1'b0}};
    tbl[6] = '{32'h0000_90E7, '{CLS_ILLEGAL,5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b0, 1'b1}};
`ifdef RISCV_DECODE_M_EXT_EN
    tbl[7] = '{32'h0273_02B3, '{CLS_MULDIV, 5'd6, 5'd7, 5'd5,  32'h0000_0000, 1'b1, 1'b0}};
`else
    tbl[7] = '{32'h0273_02B3, '{CLS_ILLEGAL,5'd0, 5'd0, 5'd0,  32'h0000_0000, 1'b0, 1'b1}};
`endif
    tbl[8] = '{32'h0080_00EF, '{CLS_JAL,    5'd0, 5'd0, 5'd1,  32'h0000_0008, 1'b1, 1'b0}};
    tbl[9] = '{32'hFFF0_2283, '{CLS_LOAD,   5'd0, 5'd0, 5'd5,  32'hFFFF_FFFF, 1'b1, 1'b0}};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    #1 chk("reset.rdy_after", 32'(in_ready), 32'd1);

    // Table-driven single instructions, downstream always ready.
    foreach (tbl[i]) begin
      @(negedge clk);
      send(tbl[i].instr, 32'h1000 + 32'(i) * 4);
      @(negedge clk);
      chk_dec($sformatf("vec%0d", i), tbl[i].instr, tbl[i].exp, 32'h1000 + 32'(i) * 4);
    end

    // Backpressure: nop held for 3 cycles while another instruction waits.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h200);
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h300;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.rdy", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.pc", c), out_pc, 32'h200);
      chk($sformatf("bp%0d.valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.cls", c), 32'(out_op_class), 32'(CLS_OPIMM));
      chk($sformatf("bp%0d.wen", c), {27'd0, out_rd, out_rd_wen}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk_dec("bp.next", 32'h0050_0093, ref_decode(32'h0050_0093), 32'h300);

    // Flush together with an accept: nothing is presented.
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h340; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush.valid", 32'(out_valid), 32'd0);
    chk("flush.cs", 32'(out_rf_cs), 32'd0);
    chk("flush.pc", out_pc, 32'd0);

    // Illegal word, then reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'h0000_0000, 32'h400);
    @(negedge clk);
    chk("ill.valid", 32'(out_valid), 32'd1);
    chk("ill.flag", 32'(out_illegal), 32'd1);
    chk("ill.cls", 32'(out_op_class), 32'(CLS_ILLEGAL));
    chk("ill.wen", 32'(out_rd_wen), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_stall");
    rst = 1'b0; out_ready = 1'b1;

    // Randomized stream with random backpressure and occasional flushes.
    ev = 1'b0; ed = ref_decode(32'h0); epc = 0; ein = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.valid", 32'(out_valid), 32'(ev));
      if (ev) chk_dec($sformatf("rnd%0d", c), ein, ed, epc);
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      exp_rdy   = !ev || out_ready;
      #1 chk("rnd.rdy", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (flush) ev = 1'b0;
      else if (in_valid && exp_rdy) begin
        ev = 1'b1; ed = ref_decode(in_instr); epc = in_pc; ein = in_instr;
      end else if (out_ready) ev = 1'b0;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
